// File: rtl/top_if.sv
// top_if: patch input and filtered block output of the 3x3 median filter.
interface top_if;
    logic [559:0] pixel_in;
    logic         valid;
    logic [287:0] pixel_out;

    modport master (output pixel_in, input valid, pixel_out);
    modport slave (input pixel_in, output valid, pixel_out);
endinterface

// File: rtl/top.sv
// top: 3x3 median filter over a 5x14 patch, producing a 3x12 block every cycle.
module top (
    input logic   clk,
    input logic   rst_n,
    top_if.slave  bus
);
    logic [559:0] in_q;
    logic [287:0] med;
    logic [1:0]   cnt;

    // A window value is the median when at most 4 values lie below it and at least 5 are at or below it.
    function automatic logic [7:0] med9(input logic [559:0] p, input int i, input int j);
        logic [7:0] v [9];
        logic [7:0] m;
        int lt;
        int le;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[3*r+c] = p[559-8*(14*(i+r)+j+c) -: 8];
        m = v[0];
        for (int k = 0; k < 9; k++) begin
            lt = 0;
            le = 0;
            for (int n = 0; n < 9; n++) begin
                if (v[n] < v[k]) lt++;
                if (v[n] <= v[k]) le++;
            end
            if (lt <= 4 && le >= 5) m = v[k];
        end
        return m;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 12; j++) begin : g_col
            assign med[287-8*(12*i+j) -: 8] = med9(in_q, i, j);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q          <= '0;
            bus.pixel_out <= '0;
            cnt           <= '0;
        end else begin
            in_q          <= bus.pixel_in;
            bus.pixel_out <= med;
            cnt           <= cnt[1] ? cnt : cnt + 2'd1;
        end
    end

    assign bus.valid = cnt[1];
endmodule

// File: tb/tb_top.sv
// tb_top: vector table, corner sequences and random streaming against a sort-based median model.
module tb_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    top_if bus();
    top dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int total = 0;
    int bad = 0;

    typedef struct {
        string        name;
        logic [559:0] pin;
        logic [287:0] exp;
    } vec_t;
    vec_t vecs[5];
    logic [287:0] q[$];

    function automatic logic [559:0] setpx(input logic [559:0] p, input int r, input int c, input logic [7:0] v);
        logic [559:0] o = p;
        o[559-8*(14*r+c) -: 8] = v;
        return o;
    endfunction

    function automatic logic [287:0] model(input logic [559:0] p);
        logic [287:0] o = '0;
        int w [9];
        int t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 12; j++) begin
                for (int k = 0; k < 9; k++)
                    w[k] = int'(p[559-8*(14*(i+k/3)+j+k%3) -: 8]);
                for (int a = 0; a < 9; a++)
                    for (int b = 0; b < 8 - a; b++)
                        if (w[b] > w[b+1]) begin
                            t = w[b]; w[b] = w[b+1]; w[b+1] = t;
                        end
                o[287-8*(12*i+j) -: 8] = 8'(w[4]);
            end
        return o;
    endfunction

    function automatic logic [559:0] rand_patch();
        logic [559:0] p = '0;
        logic narrow = 1'($urandom_range(0, 1));
        for (int k = 0; k < 70; k++)
            p[559-8*k -: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
        return p;
    endfunction

    task automatic check(input string n, input logic [287:0] act, input logic [287:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic run_stream(input int n, input logic fresh);
        logic [559:0] p;
        for (int t = 0; t < n; t++) begin
            check("stream_valid", {287'd0, bus.valid}, {287'd0, (!fresh || t >= 2)});
            if (q.size() == 2) check("stream_data", bus.pixel_out, q.pop_front());
            p = rand_patch();
            bus.pixel_in = p;
            q.push_back(model(p));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [559:0] p;
        logic [287:0] e;
        vecs[0] = '{"const55", {70{8'h55}}, {36{8'h55}}};
        vecs[1] = '{"impulse", setpx('0, 2, 5, 8'hFF), '0};
        p = '0;
        p = setpx(p, 0, 0, 8'hFF); p = setpx(p, 0, 1, 8'hFF);
        p = setpx(p, 0, 2, 8'hFF); p = setpx(p, 1, 0, 8'hFF);
        vecs[2] = '{"four_ff", p, '0};
        e = '0;
        e[287 -: 8] = 8'hFF;
        vecs[3] = '{"five_ff", setpx(p, 1, 1, 8'hFF), e};
        p = '0;
        e = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 14; c++) p = setpx(p, r, c, 8'(20*r+c));
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 12; j++) e[287-8*(12*i+j) -: 8] = 8'(20*(i+1)+(j+1));
        vecs[4] = '{"ordering", p, e};

        bus.pixel_in = '0;
        @(negedge clk);
        check("rst_out", bus.pixel_out, '0);
        check("rst_valid", {287'd0, bus.valid}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("valid_edge1", {287'd0, bus.valid}, '0);
        @(negedge clk);
        check("valid_edge2", {287'd0, bus.valid}, 288'd1);

        foreach (vecs[k]) begin
            bus.pixel_in = vecs[k].pin;
            @(negedge clk);
            @(negedge clk);
            check(vecs[k].name, bus.pixel_out, vecs[k].exp);
            check({vecs[k].name, "_model"}, bus.pixel_out, model(vecs[k].pin));
            check({vecs[k].name, "_valid"}, {287'd0, bus.valid}, 288'd1);
        end

        run_stream(150, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out", bus.pixel_out, '0);
        check("midrst_valid", {287'd0, bus.valid}, '0);
        @(negedge clk);
        check("midrst_hold", bus.pixel_out, '0);
        q.delete();
        rst_n = 1'b1;
        run_stream(100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
